// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into one-cycle press/release/click/double-click/long/repeat events.
// Define BTN_AUTOREPEAT_EN to generate repeat_pulse while a long press is held.
module btn_event_decoder #(
    parameter int LONG_CYCLES   = 100,
    parameter int REPEAT_CYCLES = 20,
    parameter int DCLICK_CYCLES = 30
) (
    input  logic clk,
    input  logic rst,
    input  logic db_in,
    output logic held,
    output logic press_pulse,
    output logic release_pulse,
    output logic click,
    output logic dbl_click,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int MAX_LR  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int MAX_ALL = (MAX_LR > DCLICK_CYCLES) ? MAX_LR : DCLICK_CYCLES;
    localparam int CW      = $clog2(MAX_ALL) + 1;

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESSED,
        LONG,
        WAIT2,
        PRESSED2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q;
    logic          held_q, held_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          click_q, click_d;
    logic          dbl_q, dbl_d;
    logic          long_q, long_d;
    logic          repeat_q, repeat_d;
    logic          rise;

    assign rise = db_in & ~prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ARM;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dbl_q     <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= db_in;
            held_q    <= held_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dbl_q     <= dbl_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    // The shared counter advances by default and is cleared on every state change.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        held_d    = (state_q == ARM) ? 1'b0 : db_in;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dbl_d     = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        unique case (state_q)
            ARM: begin
                cnt_d = '0;
                if (!db_in) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                cnt_d = '0;
                if (rise) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!db_in) begin
                    state_d   = WAIT2;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else if (cnt_q == CW'(LONG_CYCLES - 1)) begin
                    state_d = LONG;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end
            end
            LONG: begin
                if (!db_in) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
`ifdef BTN_AUTOREPEAT_EN
                    if (cnt_q == CW'(REPEAT_CYCLES - 1)) begin
                        cnt_d    = '0;
                        repeat_d = 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            WAIT2: begin
                // A second press landing on the timeout edge still counts as a double click.
                if (rise) begin
                    state_d = PRESSED2;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    dbl_d   = 1'b1;
                end else if (cnt_q == CW'(DCLICK_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    click_d = 1'b1;
                end
            end
            PRESSED2: begin
                cnt_d = '0;
                if (!db_in) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
    end

    assign held          = held_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign click         = click_q;
    assign dbl_click     = dbl_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;

endmodule
